// File: rtl/quad_updown_decoder.sv
// Quadrature (A/B) phase decoder with a wrapping up/down position count.
//
// Ports:
//   clk     - single clock, all logic on the rising edge
//   rst     - asynchronous, active-low reset
//   enable  - 1: legal steps update count/dir/step; 0: phase tracked only
//   clear   - synchronous count clear, active-high, beats a same-cycle step
//   quad_a  - phase A, asynchronous to clk
//   quad_b  - phase B, asynchronous to clk
//   count   - WIDTH-bit position count, wraps modulo 2**WIDTH
//   dir     - direction of the last counted step (1 = up, 0 = down)
//   step    - one-cycle pulse per counted step
//   err     - one-cycle pulse when both phases change in the same sample
module quad_updown_decoder #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             quad_a,
    input  logic             quad_b,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err
);

    typedef enum logic {
        PRIME,
        TRACK
    } state_e;

    // PRIME is held until the synchronizers have been refilled with real pin
    // levels; otherwise their reset zeros would look like motion from 00.
    localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES);

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] a_sync_q;
    logic [SYNC_STAGES-1:0] b_sync_q;
    logic [1:0]             ab_s;

    logic [1:0]       prev_ab_q, prev_ab_d;
    logic [2:0]       prime_cnt_q, prime_cnt_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             err_q, err_d;

    logic fwd;
    logic rev;
    logic dbl;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], quad_a};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], quad_b};
        end
    end

    assign ab_s = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PRIME;
            prime_cnt_q <= '0;
            prev_ab_q   <= '0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            prev_ab_q   <= prev_ab_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        // prev_ab follows the synchronized phase every cycle, including
        // while disabled, so re-enabling never counts stale motion.
        prev_ab_d   = ab_s;
        case (state_q)
            PRIME: begin
                if (prime_cnt_q == PRIME_LAST) begin
                    state_d = TRACK;
                end else begin
                    prime_cnt_d = prime_cnt_q + 3'd1;
                end
            end
            TRACK: begin
                state_d = TRACK;
            end
            default: begin
                state_d = PRIME;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transition decode (Gray order 00->01->11->10->00 is up)
    // ------------------------------------------------------------------
    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        case ({prev_ab_q, ab_s})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: rev = 1'b1;
            default: begin
                fwd = 1'b0;
                rev = 1'b0;
            end
        endcase
        dbl = &(prev_ab_q ^ ab_s);
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = 1'b0;
        if (state_q == TRACK) begin
            if (dbl) begin
                err_d = 1'b1;
            end else if ((fwd || rev) && enable) begin
                step_d  = 1'b1;
                dir_d   = fwd;
                count_d = fwd ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end
        end
        // A same-cycle step is still reported on step/dir, just not accumulated.
        if (clear) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            dir_q   <= 1'b1;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign step  = step_q;
    assign err   = err_q;

endmodule
